// File: rtl/lsu_rd_xbar_pkg.sv
// Shared definitions for the LSU read crossbar: FSM states, target encoding,
// AXI response codes and the default region map used by CLINT and memory.
package lsu_rd_xbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } xbar_state_e;

  typedef enum logic [1:0] {
    TGT_MEM   = 2'd0,
    TGT_CLINT = 2'd1,
    TGT_ERR   = 2'd2
  } rd_tgt_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DEF_CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] DEF_CLINT_MASK = 32'hFFFF_0000;
  localparam logic [31:0] DEF_MEM_BASE   = 32'h8000_0000;
  localparam logic [31:0] DEF_MEM_MASK   = 32'hF800_0000;

  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/lsu_rd_addr_decode.sv
// Combinational address-to-target decoder; CLINT takes priority over memory
// if the two regions are ever configured to overlap.
module lsu_rd_addr_decode
  import lsu_rd_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
  parameter logic [31:0] CLINT_MASK = DEF_CLINT_MASK,
  parameter logic [31:0] MEM_BASE   = DEF_MEM_BASE,
  parameter logic [31:0] MEM_MASK   = DEF_MEM_MASK
) (
  input  logic [31:0] addr_i,
  output rd_tgt_e     tgt_o
);

  always_comb begin
    tgt_o = TGT_ERR;
    if (region_hit(addr_i, MEM_BASE, MEM_MASK)) tgt_o = TGT_MEM;
    if (region_hit(addr_i, CLINT_BASE, CLINT_MASK)) tgt_o = TGT_CLINT;
  end

endmodule

// File: rtl/lsu_rd_xbar.sv
// Single-outstanding AXI4-Lite read crossbar: LSU master to memory or CLINT,
// unmapped reads answered locally with DECERR.
module lsu_rd_xbar
  import lsu_rd_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
  parameter logic [31:0] CLINT_MASK = DEF_CLINT_MASK,
  parameter logic [31:0] MEM_BASE   = DEF_MEM_BASE,
  parameter logic [31:0] MEM_MASK   = DEF_MEM_MASK
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_m_araddr,
  input  logic        i_m_arvalid,
  output logic        o_m_arready,
  output logic [31:0] o_m_rdata,
  output logic [1:0]  o_m_rresp,
  output logic        o_m_rvalid,
  input  logic        i_m_rready,
  output logic [31:0] o_mem_araddr,
  output logic        o_mem_arvalid,
  input  logic        i_mem_arready,
  input  logic [31:0] i_mem_rdata,
  input  logic [1:0]  i_mem_rresp,
  input  logic        i_mem_rvalid,
  output logic        o_mem_rready,
  output logic [31:0] o_clint_araddr,
  output logic        o_clint_arvalid,
  input  logic        i_clint_arready,
  input  logic [31:0] i_clint_rdata,
  input  logic [1:0]  i_clint_rresp,
  input  logic        i_clint_rvalid,
  output logic        o_clint_rready,
  output logic [1:0]  o_dbg_state
);

  // Handshakes are strict AXI valid/ready: a beat transfers on the rising
  // edge where both are high; valid never waits on ready.
  xbar_state_e state_q, state_d;
  rd_tgt_e     tgt_q, dec_tgt;
  logic [31:0] addr_q;
  logic        ar_hs;
  logic        sel_arready;

  lsu_rd_addr_decode #(
    .CLINT_BASE(CLINT_BASE),
    .CLINT_MASK(CLINT_MASK),
    .MEM_BASE  (MEM_BASE),
    .MEM_MASK  (MEM_MASK)
  ) u_decode (
    .addr_i(i_m_araddr),
    .tgt_o (dec_tgt)
  );

  assign o_m_arready = (state_q == ST_IDLE);
  assign ar_hs       = i_m_arvalid && o_m_arready;
  assign sel_arready = (tgt_q == TGT_CLINT) ? i_clint_arready : i_mem_arready;
  assign o_dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ar_hs) state_d = (dec_tgt == TGT_ERR) ? ST_ERR : ST_ADDR;
      ST_ADDR: if (sel_arready) state_d = ST_DATA;
      ST_DATA: if (o_m_rvalid && i_m_rready) state_d = ST_IDLE;
      ST_ERR:  if (i_m_rready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      tgt_q   <= TGT_ERR;
    end else begin
      state_q <= state_d;
      if (ar_hs) begin
        addr_q <= i_m_araddr;
        tgt_q  <= dec_tgt;
      end
    end
  end

  // Both slaves see the latched address; only arvalid is steered.
  assign o_mem_araddr    = addr_q;
  assign o_clint_araddr  = addr_q;
  assign o_mem_arvalid   = (state_q == ST_ADDR) && (tgt_q == TGT_MEM);
  assign o_clint_arvalid = (state_q == ST_ADDR) && (tgt_q == TGT_CLINT);

  always_comb begin
    o_m_rvalid     = 1'b0;
    o_m_rdata      = '0;
    o_m_rresp      = RESP_OKAY;
    o_mem_rready   = 1'b0;
    o_clint_rready = 1'b0;
    case (state_q)
      ST_DATA: begin
        if (tgt_q == TGT_CLINT) begin
          o_m_rvalid     = i_clint_rvalid;
          o_m_rdata      = i_clint_rdata;
          o_m_rresp      = i_clint_rresp;
          o_clint_rready = i_m_rready;
        end else begin
          o_m_rvalid   = i_mem_rvalid;
          o_m_rdata    = i_mem_rdata;
          o_m_rresp    = i_mem_rresp;
          o_mem_rready = i_m_rready;
        end
      end
      ST_ERR: begin
        o_m_rvalid = 1'b1;
        o_m_rresp  = RESP_DECERR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_rd_xbar.sv
// Bench for lsu_rd_xbar: behavioural memory/CLINT slaves, a region-rule
// reference model feeding an expected queue, and a monitor that scores R beats.
module tb_lsu_rd_xbar;

  logic        clk;
  logic        i_reset;
  logic [31:0] i_m_araddr;
  logic        i_m_arvalid;
  logic        o_m_arready;
  logic [31:0] o_m_rdata;
  logic [1:0]  o_m_rresp;
  logic        o_m_rvalid;
  logic        i_m_rready;
  logic [31:0] o_mem_araddr;
  logic        o_mem_arvalid;
  logic        i_mem_arready;
  logic [31:0] i_mem_rdata;
  logic [1:0]  i_mem_rresp;
  logic        i_mem_rvalid;
  logic        o_mem_rready;
  logic [31:0] o_clint_araddr;
  logic        o_clint_arvalid;
  logic        i_clint_arready;
  logic [31:0] i_clint_rdata;
  logic [1:0]  i_clint_rresp;
  logic        i_clint_rvalid;
  logic        o_clint_rready;
  logic [1:0]  o_dbg_state;

  lsu_rd_xbar dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_m_araddr(i_m_araddr), .i_m_arvalid(i_m_arvalid), .o_m_arready(o_m_arready),
    .o_m_rdata(o_m_rdata), .o_m_rresp(o_m_rresp), .o_m_rvalid(o_m_rvalid), .i_m_rready(i_m_rready),
    .o_mem_araddr(o_mem_araddr), .o_mem_arvalid(o_mem_arvalid), .i_mem_arready(i_mem_arready),
    .i_mem_rdata(i_mem_rdata), .i_mem_rresp(i_mem_rresp), .i_mem_rvalid(i_mem_rvalid),
    .o_mem_rready(o_mem_rready),
    .o_clint_araddr(o_clint_araddr), .o_clint_arvalid(o_clint_arvalid),
    .i_clint_arready(i_clint_arready), .i_clint_rdata(i_clint_rdata),
    .i_clint_rresp(i_clint_rresp), .i_clint_rvalid(i_clint_rvalid),
    .o_clint_rready(o_clint_rready), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Region: 0 = memory, 1 = CLINT, 2 = unmapped.
  function automatic int ref_region(input logic [31:0] a);
    if (a[31:16] == 16'h0200) return 1;
    if (a[31:27] == 5'b10000) return 0;
    return 2;
  endfunction

  function automatic logic [31:0] clint_word(input logic [31:0] a);
    return a[2] ? (32'hC1A7_0000 | {16'h0, a[15:0]}) : (32'd5 + {16'h0, a[15:0]});
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return a[8] ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [33:0] ref_beat(input logic [31:0] a);
    case (ref_region(a))
      0:       return {mem_resp(a), mem_word(a)};
      1:       return {2'b00, clint_word(a)};
      default: return {2'b11, 32'h0};
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- slave models ----------------
  int          rmode = 2;        // 0 random, 1 hold low, 2 always high
  int          mem_need_fixed = -1;
  logic        mem_busy, clint_busy;
  logic [31:0] mem_addr, clint_addr;
  int          mem_dly, mem_wait, mem_need;

  always @(posedge clk) begin
    if (i_reset) begin
      mem_busy <= 1'b0; i_mem_rvalid <= 1'b0; mem_wait <= 0; mem_need <= 0; mem_dly <= 0;
      i_mem_rdata <= '0; i_mem_rresp <= '0;
    end else begin
      if (o_mem_arvalid && i_mem_arready) begin
        mem_busy <= 1'b1; mem_addr <= o_mem_araddr; mem_dly <= $urandom_range(0, 3);
        mem_wait <= 0; mem_need <= $urandom_range(0, 2);
      end else if (o_mem_arvalid) mem_wait <= mem_wait + 1;
      if (mem_busy && !i_mem_rvalid) begin
        if (mem_dly == 0) begin
          i_mem_rvalid <= 1'b1; i_mem_rdata <= mem_word(mem_addr); i_mem_rresp <= mem_resp(mem_addr);
        end else mem_dly <= mem_dly - 1;
      end
      if (i_mem_rvalid && o_mem_rready) begin i_mem_rvalid <= 1'b0; mem_busy <= 1'b0; end
    end
  end

  // CLINT answers on the edge after its AR handshake.
  always @(posedge clk) begin
    if (i_reset) begin
      clint_busy <= 1'b0; i_clint_rvalid <= 1'b0; i_clint_rdata <= '0; i_clint_rresp <= '0;
    end else begin
      if (o_clint_arvalid && i_clint_arready) begin
        clint_busy <= 1'b1; clint_addr <= o_clint_araddr;
      end
      if (clint_busy && !i_clint_rvalid) begin
        i_clint_rvalid <= 1'b1; i_clint_rdata <= clint_word(clint_addr); i_clint_rresp <= 2'b00;
      end
      if (i_clint_rvalid && o_clint_rready) begin i_clint_rvalid <= 1'b0; clint_busy <= 1'b0; end
    end
  end

  always @(negedge clk) begin
    i_mem_arready   = o_mem_arvalid && !mem_busy &&
                      (mem_wait >= ((mem_need_fixed >= 0) ? mem_need_fixed : mem_need));
    i_clint_arready = !clint_busy;
    i_m_rready      = (rmode == 2) ? 1'b1 : (rmode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  logic        checks_on = 1'b0;
  logic        tb_busy = 1'b0;
  logic [31:0] ar_addr = '0;
  int          ar_cyc, sar_cyc, rv_cyc, mhs_cyc;
  logic        sar_seen, rv_seen;
  logic        hold_pend = 1'b0;
  logic [33:0] prev_beat;

  always begin
    @(negedge clk);
    #2;
    if (checks_on) begin
      if (hold_pend) begin
        chk("rvalid_hold", 34'(o_m_rvalid), 34'd1);
        chk("rbeat_hold", {o_m_rresp, o_m_rdata}, prev_beat);
      end
      chk("arready_idle", 34'(o_m_arready), 34'(!tb_busy));
      if (tb_busy) begin
        chk("mem_araddr", 34'(o_mem_araddr), 34'(ar_addr));
        chk("clint_araddr", 34'(o_clint_araddr), 34'(ar_addr));
      end
      if (o_mem_arvalid) chk("mem_ar_sel", 34'(tb_busy && ref_region(ar_addr) == 0), 34'd1);
      if (o_clint_arvalid) chk("clint_ar_sel", 34'(tb_busy && ref_region(ar_addr) == 1), 34'd1);
      if (o_mem_rready) chk("mem_r_sel", 34'(ref_region(ar_addr) == 0 && i_m_rready), 34'd1);
      if (o_clint_rready) chk("clint_r_sel", 34'(ref_region(ar_addr) == 1 && i_m_rready), 34'd1);
      if (o_m_rvalid && i_m_rready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 34'(o_m_rvalid), 34'd0);
        else chk("rbeat", {o_m_rresp, o_m_rdata}, exp_q.pop_front());
      end
    end
    if (o_m_rvalid && i_m_rready) tb_busy = 1'b0;
    if (!sar_seen && (o_mem_arvalid || o_clint_arvalid)) begin sar_cyc = cyc; sar_seen = 1'b1; end
    if (!rv_seen && o_m_rvalid) begin rv_cyc = cyc; rv_seen = 1'b1; end
    if (o_mem_arvalid && i_mem_arready) mhs_cyc = cyc;
    if (i_m_arvalid && o_m_arready) begin
      tb_busy = 1'b1; ar_addr = i_m_araddr; ar_cyc = cyc; sar_seen = 1'b0; rv_seen = 1'b0;
    end
    hold_pend = o_m_rvalid && !i_m_rready;
    prev_beat = {o_m_rresp, o_m_rdata};
    if (i_reset) begin tb_busy = 1'b0; hold_pend = 1'b0; exp_q.delete(); end
  end

  // ---------------- driver tasks ----------------
  task automatic rd(input logic [31:0] a);
    int t = 0;
    @(negedge clk);
    while (!o_m_arready && t < 200) begin
      // Stray arvalid while busy must never be latched.
      i_m_arvalid = ($urandom_range(0, 3) == 0);
      i_m_araddr  = $urandom;
      t++;
      @(negedge clk);
    end
    if (t >= 200) chk("ar_timeout", 34'(o_m_arready), 34'd1);
    i_m_arvalid = 1'b1;
    i_m_araddr  = a;
    exp_q.push_back(ref_beat(a));
    @(negedge clk);
    i_m_arvalid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    do begin @(negedge clk); #3; t++; end while (tb_busy && t < 200);
    chk("done_timeout", 34'(tb_busy), 34'd0);
  endtask

  task automatic wait_rvalid();
    int t = 0;
    do begin @(negedge clk); #3; t++; end while (!o_m_rvalid && t < 200);
    chk("rvalid_timeout", 34'(o_m_rvalid), 34'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return 32'h0200_0000 | ($urandom & 32'h0000_FFFC);
      1:       return 32'h8000_0000 | ($urandom & 32'h07FF_FFFC);
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  logic [31:0] bnd_addrs [6] = '{32'h0201_0000, 32'h01FF_FFFC, 32'h87FF_FFFC,
                                 32'h8800_0000, 32'h7FFF_FFFC, 32'h0200_FFFC};

  // ---------------- stimulus ----------------
  initial begin
    i_reset = 1'b1; i_m_arvalid = 1'b0; i_m_araddr = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_arready", 34'(o_m_arready), 34'd1);
    chk("rst_rvalid", 34'(o_m_rvalid), 34'd0);
    chk("rst_rbeat", {o_m_rresp, o_m_rdata}, 34'd0);
    chk("rst_arvalids", 34'({o_mem_arvalid, o_clint_arvalid}), 34'd0);
    chk("rst_rreadys", 34'({o_mem_rready, o_clint_rready}), 34'd0);
    chk("rst_araddr", 34'(o_mem_araddr | o_clint_araddr), 34'd0);
    chk("rst_state", 34'(o_dbg_state), 34'd0);
    @(negedge clk);
    i_reset = 1'b0;
    checks_on = 1'b1;

    // CLINT low word: slave arvalid next cycle, rvalid three cycles after.
    rd(32'h0200_0000); wait_done();
    chk("clint_ar_lat", 34'(sar_cyc - ar_cyc), 34'd1);
    chk("clint_rv_lat", 34'(rv_cyc - ar_cyc), 34'd3);
    rd(32'h0200_0004); wait_done();

    // Memory with arready held off for three cycles.
    mem_need_fixed = 3;
    rd(32'h8000_0010); wait_done();
    chk("mem_ar_lat", 34'(sar_cyc - ar_cyc), 34'd1);
    chk("mem_hs_lat", 34'(mhs_cyc - ar_cyc), 34'd4);
    mem_need_fixed = -1;

    // Unmapped address.
    rd(32'h1000_0000); wait_done();
    chk("err_rv_lat", 34'(rv_cyc - ar_cyc), 34'd1);
    chk("err_no_slave_ar", 34'(sar_seen), 34'd0);

    // Master stalls the R channel during a CLINT read.
    rmode = 1;
    rd(32'h0200_0008); wait_rvalid();
    repeat (4) @(negedge clk);
    rmode = 2;
    wait_done();

    // Reset while a CLINT beat is waiting in DATA.
    rmode = 1;
    rd(32'h0200_000C); wait_rvalid();
    @(negedge clk); i_reset = 1'b1;
    @(negedge clk); i_reset = 1'b0;
    #2;
    chk("mid_rst_arready", 34'(o_m_arready), 34'd1);
    chk("mid_rst_valids", 34'({o_m_rvalid, o_mem_arvalid, o_clint_arvalid}), 34'd0);
    rmode = 2;
    rd(32'h0200_0000); wait_done();

    // Region boundaries with a randomly stalling master.
    rmode = 0;
    foreach (bnd_addrs[i]) begin rd(bnd_addrs[i]); wait_done(); end

    for (int i = 0; i < 150; i++) rd(rand_addr());
    wait_done();
    chk("drain", 34'(exp_q.size()), 34'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_rd_xbar.md
# lsu_rd_xbar

Single-outstanding AXI4-Lite read crossbar between the LSU read master and two read slaves: main memory and the CLINT timer. It decodes each read address, forwards it to exactly one slave, and returns that slave's data and response to the master. Addresses that hit neither region complete locally with DECERR. It sits directly upstream of the CLINT and feeds its AR channel and consumes its R channel.

## Interface
- CLINT_BASE, 32'h0200_0000, CLINT region base
- CLINT_MASK, 32'hFFFF_0000, address bits compared for the CLINT hit
- MEM_BASE, 32'h8000_0000, memory region base
- MEM_MASK, 32'hF800_0000, address bits compared for the memory hit
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_m_araddr / i_m_arvalid / o_m_arready  in/in/out  32/1/1  master AR channel
- o_m_rdata / o_m_rresp / o_m_rvalid / i_m_rready  out/out/out/in  32/2/1/1  master R channel
- o_mem_araddr / o_mem_arvalid / i_mem_arready  out/out/in  32/1/1  memory AR channel
- i_mem_rdata / i_mem_rresp / i_mem_rvalid / o_mem_rready  in/in/in/out  32/2/1/1  memory R channel
- o_clint_araddr / o_clint_arvalid / i_clint_arready  out/out/in  32/1/1  CLINT AR channel
- i_clint_rdata / i_clint_rresp / i_clint_rvalid / o_clint_rready  in/in/in/out  32/2/1/1  CLINT R channel

## Operation
- Decode is done on i_m_araddr while in IDLE.
  - CLINT hit: (addr & CLINT_MASK) == CLINT_BASE.
  - Memory hit: (addr & MEM_MASK) == MEM_BASE.
  - If both hit, CLINT wins.
  - If neither hits, target is ERR.
- FSM states: IDLE, ADDR, DATA, ERR.
  - IDLE: o_m_arready=1. On arvalid&&arready, latch the address and target. Go to ADDR for a slave target, or to ERR for an unmapped address.
  - ADDR: assert arvalid to the selected slave only, with the latched address. On that slave's arready, go to DATA. The address stays stable until the handshake.
  - DATA: pass the selected slave's rdata, rresp and rvalid combinationally to the master. The selected slave's rready equals i_m_rready; the other slave's rready is 0. On master rvalid&&rready, go to IDLE.
  - ERR: o_m_rvalid=1, o_m_rresp=2'b11, o_m_rdata=0. On i_m_rready, go to IDLE.
- Only one transaction is in flight. o_m_arready is 0 outside IDLE.
- o_*_araddr always carries the latched address. Only arvalid is gated per slave.
- An R-channel beat from an unselected slave is ignored: its rready is held at 0.

## Timing
- Reset values: state IDLE; o_m_arready=1; all other valids and readys 0; o_m_rdata=0; o_m_rresp=0; latched address 0.
- Reset mid-transaction: the FSM returns to IDLE at the next edge and the transaction is dropped. Slaves share i_reset.
- Master AR handshake in cycle N: slave arvalid rises in N+1.
- Slave arready already high in N+1: DATA begins in N+2.
- Earliest master rvalid:
  - CLINT target: N+3 (the CLINT registers rvalid one cycle after its AR handshake).
  - ERR target: N+1.
- The next o_m_arready comes one cycle after the master R handshake. Back-to-back throughput is at most one read per 4 cycles to the CLINT.
- Slave rvalid held while i_m_rready is low: data must pass through unchanged every cycle.
- i_m_arvalid outside IDLE: ignored, never latched.

## Structure
- Shared package holds:
  - the state enum (IDLE/ADDR/DATA/ERR);
  - target encoding (TGT_MEM, TGT_CLINT, TGT_ERR);
  - RESP_OKAY=2'b00 and RESP_DECERR=2'b11;
  - default region base/mask constants, shared with the CLINT and the memory wrapper.
- One natural sub-module: lsu_rd_addr_decode, a combinational address-to-target decoder, reusable by the future write crossbar.

## Test plan
- Read 32'h0200_0000 with CLINT low word = 5 → CLINT arvalid in N+1, master gets rdata=5, rresp=0; memory arvalid never asserted.
- Read 32'h0200_0004 → master rdata equals the CLINT high word; o_clint_araddr=32'h0200_0004 throughout ADDR and DATA.
- Read 32'h8000_0010 with memory arready delayed 3 cycles → address held stable, master rdata equals memory data, single beat.
- Read 32'h1000_0000 → rvalid at N+1 with rresp=2'b11, rdata=0; neither slave sees arvalid.
- Master rready low for 4 cycles during a CLINT read → rvalid and rdata held; o_m_arready stays 0 until the handshake completes.
- i_reset asserted while in DATA → next cycle all valids 0 and o_m_arready=1; a new read then completes normally.
